// File: rtl/synth_cfg_pkg.sv
// rtl/synth_cfg_pkg.sv - shared widths, FSM state type and helpers for the config-port writer
package synth_cfg_pkg;

    localparam int CFG_DATA_W = 8;
    localparam int CFG_ADDR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } cfg_wr_state_t;

    // Larger of two integers; sizes the shared phase counter.
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/synth_cfg_fifo.sv
// rtl/synth_cfg_fifo.sv - synchronous request FIFO with registered count and full/empty flags
module synth_cfg_fifo
    import synth_cfg_pkg::*;
#(
    parameter int WIDTH = CFG_ADDR_W + CFG_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Flags derive from the registered count only, so ready never depends on this cycle's pop.
    assign o_full     = (r_count == CNT_W'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;

    // Storage array: written at the tail, no reset needed because count guards reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count tracks push minus pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/synth_cfg_writer.sv
// rtl/synth_cfg_writer.sv - buffers register writes and replays them as setup/strobe/hold on the config pins
module synth_cfg_writer
    import synth_cfg_pkg::*;
#(
    parameter int NUM_REGS      = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int STROBE_CYCLES = 1,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [CFG_ADDR_W-1:0] req_addr,
    input  logic [CFG_DATA_W-1:0] req_data,
    output logic [CFG_DATA_W-1:0] cfg_data,
    output logic [NUM_REGS-1:0]   cfg_en,
    output logic                  busy,
    output logic                  addr_err,
    input  logic                  err_clr
);

    localparam int CNT_W      = $clog2(max2(STROBE_CYCLES, HOLD_CYCLES) + 1);
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W    = CFG_ADDR_W + CFG_DATA_W;

    cfg_wr_state_t           r_state;
    cfg_wr_state_t           w_state_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [CFG_ADDR_W-1:0]   r_addr;
    logic [CFG_ADDR_W-1:0]   w_addr_nxt;
    logic [CFG_DATA_W-1:0]   r_cfg_data;
    logic [CFG_DATA_W-1:0]   w_cfg_data_nxt;
    logic [NUM_REGS-1:0]     r_cfg_en;
    logic [NUM_REGS-1:0]     w_cfg_en_nxt;
    logic                    r_busy;
    logic                    w_busy_nxt;
    logic                    r_addr_err;
    logic                    w_addr_err_nxt;

    logic                    w_push;
    logic                    w_pop;
    logic [ENTRY_W-1:0]      w_head;
    logic [CFG_ADDR_W-1:0]   w_head_addr;
    logic [CFG_DATA_W-1:0]   w_head_data;
    logic                    w_head_bad;
    logic                    w_addr_ok;
    logic [NUM_REGS-1:0]     w_onehot;
    logic [FIFO_CNT_W-1:0]   w_fifo_count;
    logic [FIFO_CNT_W-1:0]   w_fifo_count_nxt;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;

    assign req_ready   = !w_fifo_full;
    assign w_push      = req_valid && !w_fifo_full;
    assign w_head_addr = w_head[CFG_DATA_W +: CFG_ADDR_W];
    assign w_head_data = w_head[CFG_DATA_W-1:0];
    assign w_head_bad  = (int'(w_head_addr) >= NUM_REGS);
    assign w_addr_ok   = (int'(r_addr) < NUM_REGS);
    assign w_onehot    = {{(NUM_REGS-1){1'b0}}, 1'b1} << r_addr;

    assign cfg_data = r_cfg_data;
    assign cfg_en   = r_cfg_en;
    assign busy     = r_busy;
    assign addr_err = r_addr_err;

    synth_cfg_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({req_addr, req_data}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and FIFO pop: a new write is fetched from IDLE or straight out of HOLD.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_nxt = ST_SETUP;
                    w_pop       = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    if (!w_fifo_empty) begin
                        w_state_nxt = ST_SETUP;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; cfg_en follows the next state so it is a clean flop output.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == ST_SETUP) begin
            w_cnt_nxt = CNT_W'(STROBE_CYCLES - 1);
        end else if (r_state == ST_STROBE && r_cnt == '0) begin
            w_cnt_nxt = CNT_W'(HOLD_CYCLES - 1);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end

        w_cfg_en_nxt = '0;
        if (w_state_nxt == ST_STROBE && w_addr_ok) begin
            w_cfg_en_nxt = w_onehot;
        end

        w_cfg_data_nxt = w_pop ? w_head_data : r_cfg_data;
        w_addr_nxt     = w_pop ? w_head_addr : r_addr;

        if (w_pop && w_head_bad) begin
            w_addr_err_nxt = 1'b1;
        end else if (err_clr) begin
            w_addr_err_nxt = 1'b0;
        end else begin
            w_addr_err_nxt = r_addr_err;
        end

        w_fifo_count_nxt = w_fifo_count + FIFO_CNT_W'(w_push) - FIFO_CNT_W'(w_pop);
        w_busy_nxt       = (w_state_nxt != ST_IDLE) || (w_fifo_count_nxt != '0);
    end

    // Output, latched-address and phase-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_cfg_data <= '0;
            r_cfg_en   <= '0;
            r_busy     <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_cfg_data <= w_cfg_data_nxt;
            r_cfg_en   <= w_cfg_en_nxt;
            r_busy     <= w_busy_nxt;
            r_addr_err <= w_addr_err_nxt;
        end
    end

endmodule

// File: tb/tb_synth_cfg_writer.sv
// tb/tb_synth_cfg_writer.sv - self-checking bench for the config-port writer, default and narrow/slow instances
module tb_synth_cfg_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       v0 = 1'b0, c0 = 1'b0;
    logic       r0, b0, e0;
    logic [2:0] a0 = '0;
    logic [7:0] d0 = '0;
    logic [7:0] cd0, en0;

    logic       v1 = 1'b0, c1 = 1'b0;
    logic       r1, b1, e1;
    logic [2:0] a1 = '0;
    logic [7:0] d1 = '0;
    logic [7:0] cd1;
    logic [3:0] en1;

    synth_cfg_writer u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(r0), .req_addr(a0), .req_data(d0),
        .cfg_data(cd0), .cfg_en(en0), .busy(b0), .addr_err(e0), .err_clr(c0)
    );

    synth_cfg_writer #(.NUM_REGS(4), .FIFO_DEPTH(4), .STROBE_CYCLES(3), .HOLD_CYCLES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1), .req_addr(a1), .req_data(d1),
        .cfg_data(cd1), .cfg_en(en1), .busy(b1), .addr_err(e1), .err_clr(c1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: queues of accepted writes per instance plus strobe-shape tracking.
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [7:0]  m_prev_en[2];
    logic [7:0]  m_prev_data[2];
    int          m_run[2], m_gap[2], m_last_gap[2], m_strobes[2], stalls[2];
    bit          m_seen[2];
    bit          bad1 = 1'b0;

    function automatic int nregs_of(input int k); return (k == 0) ? 8 : 4; endfunction
    function automatic int stb_of(input int k);   return (k == 0) ? 1 : 3; endfunction
    function automatic int hold_of(input int k);  return (k == 0) ? 1 : 2; endfunction
    function automatic int qsize(input int k);    return (k == 0) ? q0.size() : q1.size(); endfunction
    function automatic logic [10:0] qpop(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_reset();
        for (int k = 0; k < 2; k++) begin
            m_prev_en[k] = '0; m_prev_data[k] = '0; m_run[k] = 0; m_gap[k] = 0;
            m_last_gap[k] = 0; m_seen[k] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    // Checks strobe shape, framing and content against the expected write order.
    task automatic mon(input int k, input logic [7:0] en, input logic [7:0] data);
        logic [10:0] e;
        bit found;
        if (en != 0 && m_prev_en[k] == 0) begin
            chk($sformatf("mon%0d_setup_data", k), data, m_prev_data[k]);
            if (m_seen[k]) chk($sformatf("mon%0d_min_gap", k), m_gap[k] >= hold_of(k) + 1, 1);
            m_last_gap[k] = m_gap[k];
            found = 1'b0;
            e = '0;
            while (!found && qsize(k) > 0) begin
                e = qpop(k);
                if (int'(e[10:8]) < nregs_of(k)) found = 1'b1;
            end
            chk($sformatf("mon%0d_strobe_expected", k), found, 1);
            if (found) begin
                chk($sformatf("mon%0d_strobe_en", k), en, 8'(8'd1 << e[10:8]));
                chk($sformatf("mon%0d_strobe_data", k), data, e[7:0]);
            end
            m_run[k] = 1;
            m_seen[k] = 1'b1;
            m_strobes[k]++;
        end else if (en != 0) begin
            chk($sformatf("mon%0d_en_steady", k), en, m_prev_en[k]);
            chk($sformatf("mon%0d_data_steady", k), data, m_prev_data[k]);
            m_run[k]++;
        end else if (m_prev_en[k] != 0) begin
            chk($sformatf("mon%0d_strobe_len", k), m_run[k], stb_of(k));
            m_gap[k] = 1;
        end else begin
            m_gap[k]++;
        end
        m_prev_en[k] = en;
        m_prev_data[k] = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mon(0, en0, cd0);
        mon(1, {4'b0, en1}, cd1);
    endtask

    task automatic send(input int k, input logic [2:0] a, input logic [7:0] d);
        logic rdy;
        int n;
        n = 0;
        if (k == 0) begin v0 = 1'b1; a0 = a; d0 = d; end
        else begin v1 = 1'b1; a1 = a; d1 = d; end
        do begin
            rdy = (k == 0) ? r0 : r1;
            if (!rdy) stalls[k]++;
            tick();
            n++;
        end while (!rdy && n < 200);
        chk($sformatf("accept%0d", k), rdy, 1);
        if (rdy) begin
            if (k == 0) q0.push_back({a, d});
            else begin
                q1.push_back({a, d});
                if (int'(a) >= 4) bad1 = 1'b1;
            end
        end
    endtask

    task automatic idle(input int k);
        if (k == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        logic [10:0] e;
        n = 0;
        while (((k == 0) ? b0 : b1) && n < 500) begin
            tick();
            n++;
        end
        chk($sformatf("drain%0d", k), (k == 0) ? b0 : b1, 0);
        while (q1.size() > 0 && k == 1 && int'(q1[0][10:8]) >= 4) e = qpop(1);
        chk($sformatf("queue_empty%0d", k), qsize(k), 0);
    endtask

    initial begin
        int s0, s1, n, g;
        for (int k = 0; k < 2; k++) begin m_strobes[k] = 0; stalls[k] = 0; end
        mon_reset();

        #12;
        chk("rst_en0", en0, 0);       chk("rst_data0", cd0, 0);
        chk("rst_busy0", b0, 0);      chk("rst_err0", e0, 0);
        chk("rst_ready0", r0, 1);     chk("rst_en1", en1, 0);
        chk("rst_ready1", r1, 1);     chk("rst_busy1", b1, 0);
        #5 rst_n = 1'b1;
        tick();
        tick();

        // Single write: accepted at edge N.
        send(0, 3'd2, 8'hA5);
        idle(0);
        chk("single_n_busy", b0, 1);   chk("single_n_en", en0, 0);   chk("single_n_data", cd0, 0);
        tick();
        chk("single_n1_data", cd0, 8'hA5); chk("single_n1_en", en0, 0);
        tick();
        chk("single_n2_en", en0, 8'h04);
        tick();
        chk("single_n3_en", en0, 0);   chk("single_n3_busy", b0, 1);
        tick();
        chk("single_n4_busy", b0, 0);  chk("single_n4_data", cd0, 8'hA5);

        // Back-to-back burst fills the FIFO and must back-pressure.
        s0 = m_strobes[0];
        stalls[0] = 0;
        for (int i = 0; i < 10; i++) send(0, 3'($urandom_range(0, 7)), 8'($urandom));
        idle(0);
        drain(0);
        chk("burst_stalled", stalls[0] > 0, 1);
        chk("burst_strobes", m_strobes[0] - s0, 10);
        chk("burst_gap", m_last_gap[0], 2);

        // Stretched phases: back-to-back pair on the slow instance.
        send(1, 3'd0, 8'h11);
        send(1, 3'd3, 8'h22);
        idle(1);
        drain(1);
        chk("slow_gap", m_last_gap[1], 3);

        // Out-of-range register index.
        chk("err_before", e1, 0);
        s1 = m_strobes[1];
        send(1, 3'd6, 8'h5A);
        idle(1);
        drain(1);
        chk("err_set", e1, bad1);
        chk("err_no_strobe", m_strobes[1] - s1, 0);
        send(1, 3'd1, 8'h3C);
        idle(1);
        drain(1);
        chk("err_sticky", e1, 1);
        chk("err_next_strobe", m_strobes[1] - s1, 1);
        c1 = 1'b1;
        tick();
        c1 = 1'b0;
        bad1 = 1'b0;
        chk("err_clr", e1, 0);

        // Randomized traffic across both instances.
        s0 = m_strobes[0];
        s1 = m_strobes[1];
        n = 0;
        for (int i = 0; i < 60; i++) begin
            g = $urandom_range(0, 1);
            send(g, 3'($urandom_range(0, 7)), 8'($urandom));
            idle(g);
            if (g == 0 || int'(a1) < 4) n++;
            for (int j = $urandom_range(0, 3); j > 0; j--) tick();
        end
        drain(0);
        drain(1);
        chk("rand_strobes", (m_strobes[0] - s0) + (m_strobes[1] - s1), n);
        chk("rand_err1", e1, bad1);
        chk("rand_err0", e0, 0);
        c1 = 1'b1;
        tick();
        c1 = 1'b0;
        bad1 = 1'b0;
        chk("rand_err_clr", e1, 0);

        // Asynchronous reset in the middle of a strobe with requests pending.
        send(0, 3'd4, 8'hC3);
        send(0, 3'd5, 8'h3C);
        send(0, 3'd6, 8'h99);
        idle(0);
        n = 0;
        while (en0 == 0 && n < 20) begin tick(); n++; end
        chk("rst_mid_reached", en0 != 0, 1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid_en", en0, 0);     chk("rst_mid_busy", b0, 0);
        chk("rst_mid_ready", r0, 1);   chk("rst_mid_data", cd0, 0);
        #2 rst_n = 1'b1;
        mon_reset();
        s0 = m_strobes[0];
        for (int i = 0; i < 6; i++) tick();
        chk("rst_post_ready", r0, 1);
        chk("rst_post_busy", b0, 0);
        chk("rst_post_strobes", m_strobes[0] - s0, 0);
        send(0, 3'd5, 8'h77);
        idle(0);
        drain(0);
        chk("rst_post_write", m_strobes[0] - s0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
